// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic {
        ST_DRIVE  = 1'b0,
        ST_UPDATE = 1'b1
    } scan_state_e;

    // Never returns less than 1 so that single-value fields still get a bit.
    function automatic int code_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// One key's debounce state: saturating disagreement counter and debounced bit.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic update_i,
    input  logic flip_i,
    output logic stable_o,
    output logic pending_o
);

    localparam int CW = code_width(DEBOUNCE_SCANS + 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          stable_q, stable_d;

    // pending looks at the post-increment count so a key fires in the same
    // UPDATE cycle that its counter reaches the threshold.
    always_comb begin
        cnt_inc = '0;
        if (raw_i != stable_q) begin
            cnt_inc = (cnt_q == CW'(DEBOUNCE_SCANS)) ? cnt_q : cnt_q + 1'b1;
        end
        pending_o = (cnt_inc == CW'(DEBOUNCE_SCANS));
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        if (update_i) begin
            if (flip_i) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning keypad controller with per-key debounce and a valid/ready event port.
//   state     | meaning
//   ST_DRIVE  | one column driven low for COL_CYCLES, rows sampled at SETTLE_CYCLES
//   ST_UPDATE | single cycle: debounce counters advance, at most one event emitted
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 4,
    parameter int COL_CYCLES     = 100000,
    parameter int SETTLE_CYCLES  = 8,
    parameter int DEBOUNCE_SCANS = 3,
    localparam int CODE_W        = code_width(NUM_ROWS * NUM_COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_release,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              multi_key
);

    localparam int NK    = NUM_ROWS * NUM_COLS;
    localparam int CNT_W = code_width(COL_CYCLES);
    localparam int IDX_W = code_width(NUM_COLS);

    scan_state_e         state_q, state_d;
    logic [IDX_W-1:0]    col_idx_q, col_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NK-1:0]       raw_q, raw_d;
    logic [NUM_COLS-1:0] col_q, col_d;
    logic                key_valid_q, key_valid_d;
    logic [CODE_W-1:0]   key_code_q, key_code_d;
    logic                key_release_q, key_release_d;
    logic                multi_q, multi_d;

    logic [NK-1:0]       stable, pending, flip_vec;
    logic                update, any_pending, emit;
    logic [CODE_W-1:0]   sel;

    assign update = (state_q == ST_UPDATE);

    // col is registered from the current scan position, so it trails cnt by
    // one cycle; this gives column 0 its full COL_CYCLES right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_DRIVE;
            col_idx_q     <= '0;
            cnt_q         <= '0;
            raw_q         <= '0;
            col_q         <= '1;
            key_valid_q   <= 1'b0;
            key_code_q    <= '0;
            key_release_q <= 1'b0;
            multi_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_idx_q     <= col_idx_d;
            cnt_q         <= cnt_d;
            raw_q         <= raw_d;
            col_q         <= col_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_release_q <= key_release_d;
            multi_q       <= multi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        cnt_d     = cnt_q;
        if (state_q == ST_DRIVE) begin
            if (cnt_q == CNT_W'(COL_CYCLES - 1)) begin
                cnt_d = '0;
                if (col_idx_q == IDX_W'(NUM_COLS - 1)) begin
                    state_d   = ST_UPDATE;
                    col_idx_d = '0;
                end else begin
                    col_idx_d = col_idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            state_d   = ST_DRIVE;
            col_idx_d = '0;
            cnt_d     = '0;
        end
    end

    always_comb begin
        raw_d = raw_q;
        if (state_q == ST_DRIVE && cnt_q == CNT_W'(SETTLE_CYCLES)) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                raw_d[r*NUM_COLS + int'(col_idx_q)] = ~row[r];
            end
        end
    end

    always_comb begin
        any_pending = 1'b0;
        sel         = '0;
        for (int i = NK - 1; i >= 0; i--) begin
            if (pending[i]) begin
                any_pending = 1'b1;
                sel         = CODE_W'(i);
            end
        end
        emit     = update && any_pending && (!key_valid_q || key_ready);
        flip_vec = '0;
        if (emit) flip_vec[sel] = 1'b1;

        col_d = '1;
        if (state_q == ST_DRIVE) col_d[col_idx_q] = 1'b0;

        key_valid_d   = key_valid_q;
        key_code_d    = key_code_q;
        key_release_d = key_release_q;
        if (emit) begin
            key_valid_d   = 1'b1;
            key_code_d    = sel;
            key_release_d = stable[sel];
        end else if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end

        multi_d = multi_q;
        if (update) multi_d = |((stable ^ flip_vec) & ((stable ^ flip_vec) - 1'b1));
    end

    for (genvar k = 0; k < NK; k++) begin : g_key
        keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (raw_q[k]),
            .update_i (update),
            .flip_i   (flip_vec[k]),
            .stable_o (stable[k]),
            .pending_o(pending[k])
        );
    end

    assign col         = col_q;
    assign key_code    = key_code_q;
    assign key_release = key_release_q;
    assign key_valid   = key_valid_q;
    assign multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: a keypad model answers the column drive, expected events go through a queue.
module tb_keypad_scanner;

    localparam int SCAN = 65;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_release;
    logic       key_valid;
    logic       key_ready;
    logic       multi_key;

    logic [15:0] pressed;
    logic [4:0]  exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .NUM_ROWS(4), .NUM_COLS(4), .COL_CYCLES(16),
        .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2)
    ) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .key_code(key_code), .key_release(key_release),
        .key_valid(key_valid), .key_ready(key_ready), .multi_key(multi_key)
    );

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ones();
        int n = 0;
        while (col !== 4'hF && n < 200) begin
            tick();
            n++;
        end
        chk("sync_idle_col", col, 4'hF);
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (key_valid !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && key_valid === 1'b1 && key_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("event_expected", exp_q.size(), 1);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                chk("ev_code", key_code, e[3:0]);
                chk("ev_release", key_release, e[4]);
            end
        end
    end

    initial begin
        int n;
        int bad;
        rst       = 1'b1;
        key_ready = 1'b1;
        pressed   = '0;

        // reset and column stepping
        repeat (3) tick();
        chk("rst_col", col, 4'hF);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_multi", multi_key, 0);
        rst = 1'b0;
        tick();
        chk("first_col", col, 4'hE);
        repeat (15) tick();
        chk("col0_last", col, 4'hE);
        tick();
        chk("col1_first", col, 4'hD);

        // press key 6 for three scans
        wait_ones();
        pressed[6] = 1'b1;
        exp_q.push_back({1'b0, 4'd6});
        wait_valid(300, n);
        chk("press_latency", n, 2 * SCAN);
        chk("press_code", key_code, 6);
        tick();
        chk("press_pulse", key_valid, 0);
        repeat (SCAN) tick();

        // release key 6
        wait_ones();
        pressed[6] = 1'b0;
        exp_q.push_back({1'b1, 4'd6});
        wait_valid(300, n);
        chk("release_latency", n, 2 * SCAN);
        chk("release_flag", key_release, 1);
        tick();

        // bounce: one scan only
        wait_ones();
        pressed[6] = 1'b1;
        repeat (SCAN) tick();
        pressed[6] = 1'b0;
        bad = 0;
        repeat (4 * SCAN) begin
            tick();
            if (key_valid !== 1'b0) bad++;
        end
        chk("bounce_no_event", bad, 0);

        // backpressure with keys 0 and 5
        key_ready = 1'b0;
        wait_ones();
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        exp_q.push_back({1'b0, 4'd0});
        wait_valid(300, n);
        chk("bp_latency", n, 2 * SCAN);
        chk("bp_code0", key_code, 0);
        bad = 0;
        repeat (3 * SCAN) begin
            tick();
            if (key_valid !== 1'b1 || key_code !== 4'd0 || key_release !== 1'b0) bad++;
        end
        chk("bp_hold_stable", bad, 0);
        chk("bp_multi_single", multi_key, 0);
        exp_q.push_back({1'b0, 4'd5});
        key_ready = 1'b1;
        tick();
        chk("bp_valid_drop", key_valid, 0);
        wait_valid(80, n);
        chk("bp_code5", key_code, 5);
        tick();
        chk("bp_multi", multi_key, 1);

        // mid-scan reset while an event is held
        key_ready = 1'b0;
        wait_ones();
        pressed[6] = 1'b1;
        exp_q.push_back({1'b0, 4'd6});
        wait_valid(300, n);
        chk("held_valid", key_valid, 1);
        repeat (20) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("mrst_col", col, 4'hF);
        chk("mrst_valid", key_valid, 0);
        chk("mrst_code", key_code, 0);
        chk("mrst_release", key_release, 0);
        chk("mrst_multi", multi_key, 0);
        rst = 1'b0;
        key_ready = 1'b1;
        exp_q.push_back({1'b0, 4'd0});
        exp_q.push_back({1'b0, 4'd5});
        exp_q.push_back({1'b0, 4'd6});
        wait_valid(300, n);
        chk("mrst_repress_latency", n, 2 * SCAN);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
        chk("final_multi", multi_key, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 4, number of row inputs (2..8).
REQ-002 SHALL have parameter NUM_COLS, default 4, number of column outputs (2..8).
REQ-003 SHALL have parameter COL_CYCLES, default 100000, clk cycles each column is driven (1 ms at 100 MHz).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 8, cycles from column drive to row sample; legal range 1..COL_CYCLES-2.
REQ-005 SHALL have parameter DEBOUNCE_SCANS, default 3, consecutive identical full scans needed to change a key state (>=1).
REQ-006 SHALL have derived constant CODE_W = clog2(NUM_ROWS*NUM_COLS).
REQ-007 clk  in  1  single system clock; rising edge only.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 row  in  NUM_ROWS  keypad rows, active-low (pulled up).
REQ-010 col  out  NUM_COLS  keypad columns, one-cold drive, all-ones = idle.
REQ-011 key_code  out  CODE_W  event key index = row_index*NUM_COLS + col_index.
REQ-012 key_release  out  1  0 = press event, 1 = release event.
REQ-013 key_valid  out  1  event present; held until accepted.
REQ-014 key_ready  in  1  consumer accepts event when key_valid && key_ready.
REQ-015 multi_key  out  1  high while >=2 keys are debounced-pressed.

Function
REQ-016 Scan FSM SHALL have states DRIVE and UPDATE; DRIVE holds col_index 0..NUM_COLS-1 and cycle counter cnt 0..COL_CYCLES-1.
REQ-017 In DRIVE, col SHALL be all-ones except bit col_index = 0, for all COL_CYCLES cycles.
REQ-018 Row sample SHALL occur at cnt == SETTLE_CYCLES: raw bitmap bits for col_index <= ~row.
REQ-019 At cnt == COL_CYCLES-1, FSM SHALL advance col_index; after last column SHALL enter UPDATE for exactly 1 cycle with col = all-ones, then DRIVE col 0.
REQ-020 Scan period SHALL be NUM_COLS*COL_CYCLES + 1 cycles.
REQ-021 In UPDATE, per key: raw == debounced -> counter cleared; raw != debounced -> counter increments, saturating at DEBOUNCE_SCANS.
REQ-022 A key is "pending" when its counter == DEBOUNCE_SCANS.
REQ-023 In UPDATE, if any key pending and (!key_valid || key_ready), the lowest-index pending key SHALL be emitted: key_code = index, key_release = new state is released, key_valid = 1; its debounced bit flips, its counter clears.
REQ-024 At most one event SHALL be emitted per UPDATE; other pending keys stay pending (no loss).
REQ-025 If key_valid && !key_ready in UPDATE, no debounced bit SHALL flip; counters keep saturating.
REQ-026 Handshake: key_code/key_release SHALL be stable while key_valid = 1; key_valid clears the cycle after key_valid && key_ready unless a new event loads in that same UPDATE cycle.
REQ-027 A key that bounces back before reaching DEBOUNCE_SCANS SHALL produce no event.
REQ-028 multi_key SHALL be registered, derived from the debounced bitmap, updated in the UPDATE cycle.

Reset
REQ-029 On rst sampled high: col = all-ones, key_valid = 0, key_code = 0, key_release = 0, multi_key = 0, debounced bitmap = 0, raw bitmap = 0, all counters = 0, FSM = DRIVE with col_index = 0, cnt = 0.
REQ-030 Reset mid-scan or with key_valid high SHALL discard the event; first non-reset cycle drives column 0 (col bit 0 low).

Structure
REQ-031 Package keypad_pkg SHALL hold the FSM state enum and a clog2-based code-width function.
REQ-032 One sub-module keypad_debounce SHALL implement one key's saturating counter, debounced bit and pending flag; instantiated NUM_ROWS*NUM_COLS times.

Verification (NUM_ROWS=4, NUM_COLS=4, COL_CYCLES=16, SETTLE_CYCLES=4, DEBOUNCE_SCANS=2; scan = 65 cycles)
REQ-033 Reset: rst high 3 cycles -> col = 4'b1111, key_valid = 0; first cycle after -> col = 4'b1110; col = 4'b1101 16 cycles later.
REQ-034 Press: row = 4'b1101 whenever col = 4'b1011, held 3 scans, key_ready = 1 -> one key_valid pulse, key_code = 6, key_release = 0, at end of 2nd scan.
REQ-035 Bounce: same press for 1 scan only -> no key_valid.
REQ-036 Backpressure: key_ready = 0, keys 0 and 5 pressed -> key_valid with key_code = 0 held stable; raise key_ready -> next UPDATE emits key_code = 5; multi_key = 1 once both debounced.
REQ-037 Release: key 6 released after REQ-034 -> key_code = 6, key_release = 1 after 2 scans.
REQ-038 Mid-scan reset with key_valid = 1 -> next cycle all outputs at REQ-029 values; held key re-reports press after 2 scans.
